apb_bridge_n: RTL and testbench

APB_BRIDGE_N -- requirements
Module: apb_bridge_n

---
 rtl/apb_bridge_n.sv | 144 ++++++++++++++
 tb/tb_apb_bridge_n.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_n.sv
// APB bridge to NUM_SLV slaves: a single-request front end drives the
// IDLE/SETUP/ACCESS APB sequence. Each slave owns one 2^SLV_SHIFT window
// starting at BASE_ADDR. Requests outside the map fail at once, and slaves
// that never respond are aborted by an optional access timeout.
module apb_bridge_n #(
  parameter int unsigned     NUM_SLV   = 6,
  parameter int unsigned     AW        = 32,
  parameter int unsigned     DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h1000_0000,
  parameter int unsigned     SLV_SHIFT = 12,
  parameter int unsigned     TIMEOUT   = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         wdata,
  input  logic [DW/8-1:0]       wstrb,
  output logic                  ready,
  output logic                  error,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic [AW-1:0]         PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [DW-1:0]         PWDATA,
  output logic [DW/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*DW-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int unsigned IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] to_cnt;

  logic [AW-1:0] req_blk;
  logic          req_mapped;
  logic [IW-1:0] req_idx;

  logic          sel_ready;
  logic          sel_err;
  logic [DW-1:0] sel_rdata;

  // Decode the incoming request address into a slave index and a map hit.
  always_comb begin
    req_blk    = (addr >> SLV_SHIFT) - (BASE_ADDR >> SLV_SHIFT);
    req_mapped = (addr >= BASE_ADDR) && (req_blk < AW'(NUM_SLV));
    req_idx    = req_blk[IW-1:0];
  end

  // Select the response of the addressed slave; all others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DW +: DW];
      end
    end
  end

  // One-hot slave select during SETUP and ACCESS; the async reset clears it at once.
  always_comb begin
    PSEL = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      PSEL[i] = (state != ST_IDLE) && (sel_idx == IW'(i));
    end
  end

  assign PENABLE = (state == ST_ACCESS);
  assign busy    = (state != ST_IDLE);

  // Transfer sequencing, request latching, completion/abort pulse and read capture.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
      to_cnt  <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
      rdata   <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            PSTRB  <= write ? wstrb : '0;
            if (req_mapped) begin
              sel_idx <= req_idx;
              state   <= ST_SETUP;
            end else begin
              ready <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          to_cnt <= '0;
          state  <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            error <= sel_err;
            if (!PWRITE && !sel_err) begin
              rdata <= sel_rdata;
            end
          end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_n.sv
// Self-checking bench for apb_bridge_n: directed vector table, multi-cycle
// corner sequences, and randomized transfers checked against a
// transaction-level model.
module tb_apb_bridge_n;

  localparam int          NUM_SLV   = 6;
  localparam int          AW        = 32;
  localparam int          DW        = 32;
  localparam int          SLV_SHIFT = 12;
  localparam int          TIMEOUT   = 16;
  localparam logic [31:0] BASE      = 32'h1000_0000;

  logic                  PCLK;
  logic                  PRESET;
  logic                  transfer;
  logic                  write;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         wdata;
  logic [DW/8-1:0]       wstrb;
  logic                  ready;
  logic                  error;
  logic [DW-1:0]         rdata;
  logic                  busy;
  logic [AW-1:0]         PADDR;
  logic                  PWRITE;
  logic                  PENABLE;
  logic [DW-1:0]         PWDATA;
  logic [DW/8-1:0]       PSTRB;
  logic [NUM_SLV-1:0]    PSEL;
  logic [NUM_SLV*DW-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;
  logic [NUM_SLV-1:0]    PSLVERR;

  apb_bridge_n #(
    .NUM_SLV  (NUM_SLV),
    .AW       (AW),
    .DW       (DW),
    .BASE_ADDR(BASE),
    .SLV_SHIFT(SLV_SHIFT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .ready   (ready),
    .error   (error),
    .rdata   (rdata),
    .busy    (busy),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] m_rdata;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          waits;
    logic        err;
    logic [31:0] rv;
    logic        mapped;
    int          idx;
    logic        xerr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    cyc++;
  endtask

  task automatic noise();
    PREADY  = NUM_SLV'($urandom);
    PSLVERR = NUM_SLV'($urandom);
    for (int i = 0; i < NUM_SLV; i++) PRDATA[i*DW +: DW] = $urandom;
  endtask

  task automatic junk_req();
    transfer = 1'($urandom);
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    wstrb    = 4'($urandom);
  endtask

  // Reference decode: byte offset from the base, divided by the window size.
  task automatic ref_decode(input logic [31:0] a, output logic m, output int idx);
    logic [31:0] blk;
    if (a < BASE) begin
      m   = 1'b0;
      idx = 0;
    end else begin
      blk = (a - BASE) / (32'd1 << SLV_SHIFT);
      m   = (blk < NUM_SLV);
      idx = m ? int'(blk) : 0;
    end
  endtask

  task automatic idle_cycle();
    transfer = 1'b0;
    noise();
    tick();
    chk("idle_ready", ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_psel", PSEL, '0);
    chk("idle_penable", PENABLE, 1'b0);
  endtask

  // One complete request. Slave responds in ACCESS cycle number 'waits'
  // (0-based); waits >= TIMEOUT means it never responds.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int waits, input logic err,
                      input logic [31:0] rv, input logic exp_mapped, input int exp_idx,
                      input logic exp_error, output int done_cyc);
    logic [NUM_SLV-1:0] exp_sel;
    logic [3:0]         exp_strb;
    bit                 fin;
    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = wd;
    wstrb    = ws;
    noise();
    tick();
    if (!exp_mapped) begin
      chk("unmapped_ready", ready, 1'b1);
      chk("unmapped_error", error, 1'b1);
      chk("unmapped_psel", PSEL, '0);
      chk("unmapped_busy", busy, 1'b0);
      chk("unmapped_rdata", rdata, m_rdata);
      transfer = 1'b0;
      done_cyc = cyc;
      return;
    end
    exp_sel          = '0;
    exp_sel[exp_idx] = 1'b1;
    exp_strb         = wr ? ws : 4'h0;
    chk("setup_psel", PSEL, exp_sel);
    chk("setup_penable", PENABLE, 1'b0);
    chk("setup_busy", busy, 1'b1);
    chk("setup_ready", ready, 1'b0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, wd);
    chk("setup_pstrb", PSTRB, exp_strb);
    junk_req();
    noise();
    tick();
    fin = 0;
    for (int k = 0; k <= TIMEOUT && !fin; k++) begin
      chk("access_psel", PSEL, exp_sel);
      chk("access_penable", PENABLE, 1'b1);
      chk("access_ready", ready, 1'b0);
      chk("access_paddr", PADDR, a);
      chk("access_pwdata", PWDATA, wd);
      chk("access_pstrb", PSTRB, exp_strb);
      chk("access_pwrite", PWRITE, wr);
      junk_req();
      noise();
      if (k == waits) begin
        PREADY[exp_idx]               = 1'b1;
        PSLVERR[exp_idx]              = err;
        PRDATA[exp_idx*DW +: DW]      = rv;
        fin = 1;
      end else begin
        PREADY[exp_idx] = 1'b0;
        if (k == TIMEOUT - 1) fin = 1;
      end
      tick();
    end
    if (!exp_error && !wr) m_rdata = rv;
    chk("done_ready", ready, 1'b1);
    chk("done_error", error, exp_error);
    chk("done_psel", PSEL, '0);
    chk("done_penable", PENABLE, 1'b0);
    chk("done_busy", busy, 1'b0);
    chk("done_rdata", rdata, m_rdata);
    chk("done_paddr_held", PADDR, a);
    transfer = 1'b0;
    done_cyc = cyc;
  endtask

  initial begin
    int d0, d1, d2;
    logic        m;
    int          idx;
    logic [31:0] a;
    int          waits;
    logic        err;
    logic        wr;
    logic        xe;

    tbl[0] = '{1'b0, 32'h1000_2004, 32'h0,         4'hF, 0,  1'b0, 32'hCAFE_0001, 1'b1, 2, 1'b0};
    tbl[1] = '{1'b1, 32'h1000_5000, 32'h1234_5678, 4'h3, 3,  1'b0, 32'hBAD0_0000, 1'b1, 5, 1'b0};
    tbl[2] = '{1'b0, 32'h1000_6000, 32'h0,         4'h0, 0,  1'b0, 32'h0,         1'b0, 0, 1'b1};
    tbl[3] = '{1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0, 0,  1'b0, 32'h0,         1'b0, 0, 1'b1};
    tbl[4] = '{1'b0, 32'h1000_1000, 32'h0,         4'h0, 99, 1'b0, 32'h1111_1111, 1'b1, 1, 1'b1};
    tbl[5] = '{1'b0, 32'h1000_1008, 32'h0,         4'h0, 0,  1'b1, 32'hDEAD_BEEF, 1'b1, 1, 1'b1};
    tbl[6] = '{1'b1, 32'h1000_0FFC, 32'hA5A5_5A5A, 4'hF, 15, 1'b0, 32'h0,         1'b1, 0, 1'b0};
    tbl[7] = '{1'b0, 32'h1000_4010, 32'h0,         4'h0, 16, 1'b0, 32'h7777_7777, 1'b1, 4, 1'b1};
    tbl[8] = '{1'b0, 32'h1000_5FFC, 32'h0,         4'h9, 1,  1'b0, 32'h5555_AAAA, 1'b1, 5, 1'b0};
    tbl[9] = '{1'b1, 32'h1000_3000, 32'hFFFF_0000, 4'hC, 0,  1'b1, 32'h0,         1'b1, 3, 1'b1};

    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    wstrb    = '0;
    PRDATA   = '0;
    PREADY   = '0;
    PSLVERR  = '0;
    m_rdata  = '0;
    tick();
    tick();
    chk("rst_psel", PSEL, '0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_paddr", PADDR, '0);
    chk("rst_pwdata", PWDATA, '0);
    chk("rst_pstrb", PSTRB, '0);
    chk("rst_pwrite", PWRITE, 1'b0);
    PRESET = 1'b0;
    idle_cycle();

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].ws, tbl[i].waits, tbl[i].err, tbl[i].rv,
           tbl[i].mapped, tbl[i].idx, tbl[i].xerr, d0);
      idle_cycle();
    end

    // Back-to-back reads to slaves 0, 3, 0 with transfer held high.
    xfer(1'b0, 32'h1000_0010, 32'h0, 4'h0, 0, 1'b0, 32'hA000_0000, 1'b1, 0, 1'b0, d0);
    xfer(1'b0, 32'h1000_3020, 32'h0, 4'h0, 0, 1'b0, 32'hA000_0003, 1'b1, 3, 1'b0, d1);
    xfer(1'b0, 32'h1000_0030, 32'h0, 4'h0, 0, 1'b0, 32'hA000_0010, 1'b1, 0, 1'b0, d2);
    chk("b2b_gap_1", d1 - d0, 3);
    chk("b2b_gap_2", d2 - d1, 3);
    idle_cycle();

    // Reset asserted in the middle of an ACCESS cycle.
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_3000;
    noise();
    tick();
    transfer = 1'b0;
    noise();
    PREADY[3] = 1'b0;
    tick();
    chk("pre_rst_penable", PENABLE, 1'b1);
    noise();
    PREADY[3] = 1'b1;
    #2;
    PRESET = 1'b1;
    #1;
    chk("midrst_psel", PSEL, '0);
    chk("midrst_penable", PENABLE, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_rdata", rdata, '0);
    chk("midrst_paddr", PADDR, '0);
    m_rdata = '0;
    tick();
    PRESET = 1'b0;
    chk("postrst_ready", ready, 1'b0);
    idle_cycle();
    xfer(1'b0, 32'h1000_3004, 32'h0, 4'h0, 2, 1'b0, 32'h600D_0003, 1'b1, 3, 1'b0, d0);
    idle_cycle();

    // Randomized transfers against the transaction-level model.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 4 * $urandom_range(1, 1000);
        1:       a = BASE + NUM_SLV * 4096 + 4 * $urandom_range(0, 100000);
        2:       a = $urandom;
        default: a = BASE + $urandom_range(0, NUM_SLV - 1) * 4096 + 4 * $urandom_range(0, 1023);
      endcase
      if ($urandom_range(0, 7) == 0) waits = $urandom_range(TIMEOUT - 2, TIMEOUT + 3);
      else                           waits = $urandom_range(0, 3);
      err = ($urandom_range(0, 3) == 0);
      wr  = 1'($urandom);
      ref_decode(a, m, idx);
      xe = !m || (waits >= TIMEOUT) || err;
      xfer(wr, a, $urandom, 4'($urandom), waits, err, $urandom, m, idx, xe, d0);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
